sad_pingpong_frame_buffer: RTL and testbench
============================================

Name: sad_pingpong_frame_buffer

Overview:
Parametrised two-bank (ping-pong) frame store for the SAD processor. Generalises the single-bank row RAM with configurable row width and depth, a ready/valid write side, frame-completion hand-off, and release-driven bank swapping. The camera/loader writes frame N+1 into one bank while the SAD core randomly reads frame N from the other bank. Sits between the pixel loader and the SAD datapath.

Parameters:
DATA_W, 640, bits per row word.
DEPTH, 480, rows per frame. Legal range is 2..2^ADDR_W.
ADDR_W, 9, row address width.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request; the row is accepted when wr_en && wr_ready
data_in  in  DATA_W  row to write
frame_restart  in  1  discard the partially written frame in the current write bank
wr_ready  out  1  write bank available (fewer than 2 full banks)
frame_wr_done  out  1  one-cycle pulse after the last row (DEPTH-th) of a frame is accepted
rd_en  in  1  read request
readAddr  in  ADDR_W  row address within the current read bank
rd_release  in  1  reader has finished with the current read bank
data_out  out  DATA_W  read data, registered
rd_valid  out  1  data_out updated this cycle
frame_avail  out  1  at least one complete frame is readable
RAM_full  out  1  both banks full; writer stalled

Behaviour:
- State: write bank pointer wb, read bank pointer rb, row counter wr_cnt[ADDR_W:0] in 0..DEPTH-1, full_cnt in 0..2.
- Reset values: wb=0, rb=0, wr_cnt=0, full_cnt=0, data_out=0, rd_valid=0, frame_wr_done=0. Combinationally this gives wr_ready=1, frame_avail=0, RAM_full=0.
- Combinational outputs:
  - wr_ready = (full_cnt<2)
  - RAM_full = (full_cnt==2)
  - frame_avail = (full_cnt>0)
- Write, when wr_en && wr_ready && !frame_restart:
  - Store data_in at bank[wb][wr_cnt].
  - If wr_cnt==DEPTH-1: wr_cnt<=0, wb<=~wb, full_cnt++, and frame_wr_done pulses next cycle.
  - Otherwise wr_cnt++.
- Writes while RAM_full are dropped. Memory, counters and flags are unchanged.
- frame_restart has priority over wr_en in the same cycle: wr_cnt<=0, wb unchanged, no memory write. It never affects full banks.
- Read:
  - rd_en && frame_avail && readAddr<DEPTH: data_out<=bank[rb][readAddr] and rd_valid<=1 next cycle. Latency is 1 cycle.
  - Otherwise rd_valid<=0 and data_out holds its value. This covers an out-of-range address and a read while no frame is available.
- Release:
  - rd_release && frame_avail: rb<=~rb, full_cnt--.
  - rd_release with no frame available is ignored.
- A read and a release in the same cycle: the read uses the pre-release rb.
- Write completion and a valid release in the same cycle: full_cnt is unchanged, and wb and rb both toggle.
- Back-pressure: a write completing when full_cnt becomes 2 deasserts wr_ready on the next cycle.
- Reset mid-frame discards all content logically. Memory contents are not cleared.
- Invariant: when full_cnt==1, rb != wb. When full_cnt==2, rb == wb (the writer is waiting on the bank the reader holds).

Decomposition:
- sad_pkg holds the defaults ROW_W=640 and FRAME_ROWS=480, plus the ADDR_W derivation (clog2 of DEPTH).
- Sub-module sad_ram_bank: a simple dual-port array (DATA_W x DEPTH) with a synchronous write and a registered 1-cycle read.
- Instantiate sad_ram_bank twice. Select the read data by a registered copy of rb.
- Top level contains only pointers, counters and the output mux.

Test Plan:
1. Fill: with DEPTH=4, DATA_W=8, write 4 rows 0x10..0x13 -> frame_wr_done pulses one cycle after the 4th accept; frame_avail=1, wb=1. rd_en at addr 2 -> data_out=0x12 with rd_valid=1 one cycle later.
2. Ping-pong: write frame A (0xA0..0xA3) then frame B (0xB0..0xB3) -> RAM_full=1 and wr_ready=0. A 9th write is dropped. Read addr 0 returns 0xA0. After rd_release, read addr 0 returns 0xB0, and wr_ready=1 again.
3. Simultaneous: with full_cnt=1, assert the last write of a frame and rd_release in the same cycle -> full_cnt stays 1, and the next read returns rows from the newly completed bank.
4. Restart: write 2 rows, then assert frame_restart together with wr_en -> no write. The next 4 writes (0xC0..0xC3) complete the frame, and reading addr 0 gives 0xC0.
5. Illegal reads: rd_en with frame_avail=0, then rd_en at readAddr=5 (>= DEPTH) -> rd_valid=0 and data_out holds. rd_release with frame_avail=0 changes nothing.
6. Reset mid-frame: write 3 rows, then rst for 1 cycle -> all flags return to reset values and frame_avail=0. The next full frame reads back correctly.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared defaults for the SAD frame-store blocks: row geometry and address width.
package sad_pkg;
   localparam int ROW_W      = 640;
   localparam int FRAME_ROWS = 480;
   localparam int ROW_ADDR_W = $clog2(FRAME_ROWS);
endpackage

// File: rtl/sad_ram_bank.sv
// One frame bank: simple dual-port row array, synchronous write, registered 1-cycle read.
module sad_ram_bank
   import sad_pkg::*;
#(
   parameter int DATA_W = ROW_W,
   parameter int DEPTH  = FRAME_ROWS,
   parameter int ADDR_W = ROW_ADDR_W
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Array kept reset-free so it maps onto block RAM; only the output register resets.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sad_pingpong_frame_buffer.sv
// Two-bank frame store: loader fills one bank while the SAD core reads the other.
module sad_pingpong_frame_buffer
   import sad_pkg::*;
#(
   parameter int DATA_W = ROW_W,
   parameter int DEPTH  = FRAME_ROWS,
   parameter int ADDR_W = ROW_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              frame_restart,
   output logic              wr_ready,
   output logic              frame_wr_done,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] readAddr,
   input  logic              rd_release,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              frame_avail,
   output logic              RAM_full
);

   localparam logic [ADDR_W:0] LAST_ROW  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic              wb_reg;
   logic              rb_reg;
   logic              rd_sel_reg;
   logic [ADDR_W:0]   wr_cnt_reg;
   logic [1:0]        full_cnt_reg;
   logic [1:0]        full_cnt_next;
   logic              done_reg;
   logic              rd_valid_reg;
   logic              wr_fire;
   logic              wr_last;
   logic              rd_fire;
   logic              rel_fire;
   logic              bank_we [2];
   logic              bank_re [2];
   logic [DATA_W-1:0] bank_rdata [2];

   assign wr_ready    = (full_cnt_reg < 2'd2);
   assign RAM_full    = (full_cnt_reg == 2'd2);
   assign frame_avail = (full_cnt_reg != 2'd0);

   assign wr_fire  = wr_en && wr_ready && !frame_restart && !rst;
   assign wr_last  = wr_fire && (wr_cnt_reg == LAST_ROW);
   assign rd_fire  = rd_en && frame_avail && ({1'b0, readAddr} < DEPTH_LIM) && !rst;
   assign rel_fire = rd_release && frame_avail;

   // A completion and a release in the same cycle cancel out on the full count.
   always_comb begin
      full_cnt_next = full_cnt_reg;
      if (wr_last && !rel_fire) begin
         full_cnt_next = full_cnt_reg + 2'd1;
      end else if (!wr_last && rel_fire) begin
         full_cnt_next = full_cnt_reg - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_reg       <= 1'b0;
         rb_reg       <= 1'b0;
         rd_sel_reg   <= 1'b0;
         wr_cnt_reg   <= '0;
         full_cnt_reg <= 2'd0;
         done_reg     <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         full_cnt_reg <= full_cnt_next;
         done_reg     <= wr_last;
         rd_valid_reg <= rd_fire;
         if (frame_restart) begin
            wr_cnt_reg <= '0;
         end else if (wr_last) begin
            wr_cnt_reg <= '0;
            wb_reg     <= ~wb_reg;
         end else if (wr_fire) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
         // The read issued this cycle uses the pre-release bank.
         if (rd_fire) begin
            rd_sel_reg <= rb_reg;
         end
         if (rel_fire) begin
            rb_reg <= ~rb_reg;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         assign bank_we[gi] = wr_fire && (wb_reg == 1'(gi));
         assign bank_re[gi] = rd_fire && (rb_reg == 1'(gi));

         sad_ram_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
         ) u_bank (
            .clk   (clk),
            .srst  (rst),
            .we    (bank_we[gi]),
            .waddr (wr_cnt_reg[ADDR_W-1:0]),
            .wdata (data_in),
            .re    (bank_re[gi]),
            .raddr (readAddr),
            .rdata (bank_rdata[gi])
         );
      end
   endgenerate

   assign data_out      = bank_rdata[rd_sel_reg];
   assign rd_valid      = rd_valid_reg;
   assign frame_wr_done = done_reg;

endmodule

// File: tb/tb_sad_pingpong_frame_buffer.sv
// Directed bench for the ping-pong frame store with a read-data scoreboard.
module tb_sad_pingpong_frame_buffer;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              frame_restart = 1'b0;
   logic              wr_ready;
   logic              frame_wr_done;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] readAddr = '0;
   logic              rd_release = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              frame_avail;
   logic              RAM_full;

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] exp_q [$];

   sad_pingpong_frame_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .data_in       (data_in),
      .frame_restart (frame_restart),
      .wr_ready      (wr_ready),
      .frame_wr_done (frame_wr_done),
      .rd_en         (rd_en),
      .readAddr      (readAddr),
      .rd_release    (rd_release),
      .data_out      (data_out),
      .rd_valid      (rd_valid),
      .frame_avail   (frame_avail),
      .RAM_full      (RAM_full)
   );

   always #5 clk = ~clk;

   // Monitor: every rd_valid must match the oldest expected read.
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: got data_out=%0h rd_valid=1, required no read", data_out);
         end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL read_data: got %0h, required %0h", data_out, e);
            end else begin
               $display("read ok: data_out=%0h", data_out);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end else begin
         $display("check ok: %s = %0h", name, act);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic write_row(input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      data_in = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic write_frame(input logic [DATA_W-1:0] base);
      for (int i = 0; i < DEPTH; i++) write_row(base + DATA_W'(i));
   endtask

   task automatic read_row(input logic [ADDR_W-1:0] a, input logic expect_data,
                           input logic [DATA_W-1:0] e);
      rd_en    = 1'b1;
      readAddr = a;
      if (expect_data) exp_q.push_back(e);
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   task automatic release_bank();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
   endtask

   task automatic check_reset_flags(input string tag);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_frame_avail"}, 32'(frame_avail), 32'd0);
      chk({tag, "_RAM_full"}, 32'(RAM_full), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_frame_wr_done"}, 32'(frame_wr_done), 32'd0);
      chk({tag, "_data_out"}, 32'(data_out), 32'd0);
   endtask

   initial begin
      tick();
      do_reset();
      check_reset_flags("reset");

      // 1: single frame fill and read
      write_frame(8'h10);
      chk("fill_done_pulse", 32'(frame_wr_done), 32'd1);
      chk("fill_avail", 32'(frame_avail), 32'd1);
      tick();
      chk("fill_done_drop", 32'(frame_wr_done), 32'd0);
      read_row(3'd2, 1'b1, 8'h12);

      // 2: ping-pong, full stall, dropped write, release
      do_reset();
      write_frame(8'hA0);
      write_frame(8'hB0);
      chk("pp_full", 32'(RAM_full), 32'd1);
      chk("pp_ready", 32'(wr_ready), 32'd0);
      write_row(8'hEE);
      chk("pp_drop_full", 32'(RAM_full), 32'd1);
      chk("pp_drop_done", 32'(frame_wr_done), 32'd0);
      read_row(3'd0, 1'b1, 8'hA0);
      release_bank();
      chk("pp_rel_ready", 32'(wr_ready), 32'd1);
      chk("pp_rel_full", 32'(RAM_full), 32'd0);
      chk("pp_rel_avail", 32'(frame_avail), 32'd1);
      read_row(3'd0, 1'b1, 8'hB0);
      read_row(3'd3, 1'b1, 8'hB3);
      for (int i = 0; i < DEPTH - 1; i++) write_row(8'hD0 + 8'(i));
      chk("pp_d_partial", 32'(frame_wr_done), 32'd0);
      write_row(8'hD3);
      chk("pp_d_done", 32'(frame_wr_done), 32'd1);
      chk("pp_d_full", 32'(RAM_full), 32'd1);
      release_bank();
      read_row(3'd0, 1'b1, 8'hD0);

      // 3: frame completion coincident with release
      do_reset();
      write_frame(8'h10);
      for (int i = 0; i < DEPTH - 1; i++) write_row(8'h20 + 8'(i));
      rd_release = 1'b1;
      write_row(8'h23);
      rd_release = 1'b0;
      chk("sim_done", 32'(frame_wr_done), 32'd1);
      chk("sim_avail", 32'(frame_avail), 32'd1);
      chk("sim_full", 32'(RAM_full), 32'd0);
      read_row(3'd0, 1'b1, 8'h20);
      read_row(3'd3, 1'b1, 8'h23);

      // 4: frame restart beats a simultaneous write
      do_reset();
      write_row(8'h50);
      write_row(8'h51);
      frame_restart = 1'b1;
      write_row(8'h99);
      frame_restart = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) write_row(8'hC0 + 8'(i));
      chk("rs_partial_avail", 32'(frame_avail), 32'd0);
      write_row(8'hC3);
      chk("rs_done", 32'(frame_wr_done), 32'd1);
      read_row(3'd0, 1'b1, 8'hC0);
      read_row(3'd1, 1'b1, 8'hC1);

      // 5: illegal reads and an ignored release
      do_reset();
      read_row(3'd0, 1'b0, 8'h00);
      chk("ill_noframe_valid", 32'(rd_valid), 32'd0);
      release_bank();
      chk("ill_rel_avail", 32'(frame_avail), 32'd0);
      chk("ill_rel_ready", 32'(wr_ready), 32'd1);
      write_frame(8'h30);
      read_row(3'd1, 1'b1, 8'h31);
      rd_en    = 1'b1;
      readAddr = 3'd5;
      tick();
      rd_en = 1'b0;
      chk("ill_oob_valid", 32'(rd_valid), 32'd0);
      chk("ill_oob_hold", 32'(data_out), 32'h31);

      // 6: reset in the middle of a frame
      do_reset();
      for (int i = 0; i < 3; i++) write_row(8'h60 + 8'(i));
      do_reset();
      chk("mid_wr_ready", 32'(wr_ready), 32'd1);
      chk("mid_frame_avail", 32'(frame_avail), 32'd0);
      chk("mid_RAM_full", 32'(RAM_full), 32'd0);
      chk("mid_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_frame_wr_done", 32'(frame_wr_done), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) write_row(8'h70 + 8'(i));
      chk("mid_partial_done", 32'(frame_wr_done), 32'd0);
      write_row(8'h73);
      chk("mid_done", 32'(frame_wr_done), 32'd1);
      read_row(3'd0, 1'b1, 8'h70);
      read_row(3'd2, 1'b1, 8'h72);

      tick();
      tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
